// File: rtl/if_prefetch_buffer_pkg.sv
// Shared types and bus constants for the instruction prefetch buffer.
// Bus encodings and the no-op word mirror the processor's sys_defs values.
package if_prefetch_buffer_pkg;

  localparam logic [1:0]  BUS_NONE  = 2'h0;
  localparam logic [1:0]  BUS_LOAD  = 2'h1;
  localparam logic [31:0] NOOP_INST = 32'h47ff041f;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_buffer_fetch_fifo.sv
// DEPTH-entry FIFO of {PC, IR} pairs with a combinational head view and a
// flush that empties it in one cycle.
module if_prefetch_buffer_fetch_fifo
  import if_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem_reg [DEPTH];
  logic [PW-1:0]  head_reg;
  logic [PW-1:0]  tail_reg;
  logic [CW-1:0]  count_reg;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only entries between head and tail are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[tail_reg] <= push_entry;
  end

  assign head_entry = mem_reg[head_reg];
  assign count      = count_reg;

endmodule

// File: rtl/if_prefetch_buffer.sv
// Decoupled fetch front end: credit-limited sequential requests, in-order
// response capture into a small FIFO, and redirect flush with response discard.
module if_prefetch_buffer
  import if_prefetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] proc2Imem_addr,
  output logic [1:0]  proc2Imem_command,
  input  logic        Imem2proc_ack,
  input  logic        Imem2proc_valid,
  input  logic [31:0] Imem2proc_data,
  output logic        pf_valid,
  output logic [31:0] pf_PC,
  output logic [31:0] pf_NPC,
  output logic [31:0] pf_IR,
  input  logic        pf_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_reg,    fetch_pc_next;
  logic [31:0]   resp_pc_reg,     resp_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_cnt_reg, discard_cnt_next;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  head_entry;
  fetch_entry_t  push_entry;

  logic [CW:0]   credits_used;
  logic          issue;
  logic          req_fire;

  // Buffered entries plus requests in flight may never exceed DEPTH.
  assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign issue        = !rst && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
  assign req_fire     = issue && Imem2proc_ack;

  assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = fetch_pc_reg;

  assign fifo_push  = Imem2proc_valid && !redirect_valid && (discard_cnt_reg == '0);
  assign fifo_pop   = pf_valid && pf_ready && !redirect_valid;
  assign push_entry = '{pc: resp_pc_reg, ir: Imem2proc_data};

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    discard_cnt_next = discard_cnt_reg;
    if (redirect_valid) begin
      // A response landing in the redirect cycle belongs to the old path and is dropped here.
      fetch_pc_next    = word_align(redirect_pc);
      resp_pc_next     = word_align(redirect_pc);
      outstanding_next = outstanding_reg - CW'(Imem2proc_valid);
      discard_cnt_next = outstanding_reg - CW'(Imem2proc_valid);
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (Imem2proc_valid) begin
        if (discard_cnt_reg != '0) discard_cnt_next = discard_cnt_reg - 1'b1;
        else                       resp_pc_next     = resp_pc_reg + 32'd4;
      end
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(Imem2proc_valid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_cnt_reg <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_cnt_reg <= discard_cnt_next;
    end
  end

  if_prefetch_buffer_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head_entry (head_entry),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

  assign pf_valid = !fifo_empty;
  assign pf_PC    = pf_valid ? head_entry.pc : 32'h0;
  assign pf_NPC   = pf_PC + 32'd4;
  assign pf_IR    = pf_valid ? head_entry.ir : NOOP_INST;

endmodule
